// File: rtl/topaz_pkg.sv
// Shared types for the RV32E hazard controller.
// Scoreboard entry layout, forward codes and stage slots.
package topaz_pkg;
   localparam int REG_W      = 4;
   localparam int NUM_STAGES = 4;
   localparam int ST_EX      = 0;
   localparam int ST_MEMPREP = 1;
   localparam int ST_MEMEX   = 2;
   localparam int ST_WB      = 3;

   typedef enum logic [2:0] {
      FWD_RF      = 3'd0,
      FWD_EX      = 3'd1,
      FWD_MEMPREP = 3'd2,
      FWD_MEMEX   = 3'd3,
      FWD_WB      = 3'd4
   } fwd_sel_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             we;
      logic             is_load;
   } sb_entry_t;
endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ID-stage decode info in, stall/flush/forward controls out.
// slave = controller side, master = pipeline side.
interface pipeline_hazard_controller_if #(
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid;
   logic [3:0]             rs1_ID;
   logic [3:0]             rs2_ID;
   logic                   rs1_used_ID;
   logic                   rs2_used_ID;
   logic [3:0]             rd_ID;
   logic                   regfile_we_ID;
   logic                   is_load_ID;
   logic                   branch_taken_EX;
   logic                   stall;
   logic                   invalid_IF;
   logic                   invalid_ID;
   logic [2:0]             fwd_sel_rs1;
   logic [2:0]             fwd_sel_rs2;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport slave (
      input  id_valid, rs1_ID, rs2_ID,
      input  rs1_used_ID, rs2_used_ID,
      input  rd_ID, regfile_we_ID, is_load_ID,
      input  branch_taken_EX,
      output stall, invalid_IF, invalid_ID,
      output fwd_sel_rs1, fwd_sel_rs2,
      output stall_cycles
   );

   modport master (
      output id_valid, rs1_ID, rs2_ID,
      output rs1_used_ID, rs2_used_ID,
      output rd_ID, regfile_we_ID, is_load_ID,
      output branch_taken_EX,
      input  stall, invalid_IF, invalid_ID,
      input  fwd_sel_rs1, fwd_sel_rs2,
      input  stall_cycles
   );
endinterface

// File: rtl/hazard_src_resolver.sv
// Per-source bypass resolver: youngest in-flight writer wins;
// an unready youngest writer blocks any older bypass.
module hazard_src_resolver
   import topaz_pkg::*;
(
   input  logic             id_valid,
   input  logic [REG_W-1:0] rs,
   input  logic             used,
   input  sb_entry_t        sb [NUM_STAGES],
   output fwd_sel_t         sel,
   output logic             not_ready
);
   logic [NUM_STAGES-1:0] hit;

   always_comb begin
      for (int k = 0; k < NUM_STAGES; k++) begin
         hit[k] = sb[k].valid & sb[k].we &
                  (sb[k].rd == rs) & (rs != '0) &
                  used & id_valid;
      end
   end

   // Loads only become bypassable once they reach WB.
   always_comb begin
      sel       = FWD_RF;
      not_ready = 1'b0;
      priority case (1'b1)
         hit[ST_EX]: begin
            if (sb[ST_EX].is_load) not_ready = 1'b1;
            else                   sel = FWD_EX;
         end
         hit[ST_MEMPREP]: begin
            if (sb[ST_MEMPREP].is_load) not_ready = 1'b1;
            else                        sel = FWD_MEMPREP;
         end
         hit[ST_MEMEX]: begin
            if (sb[ST_MEMEX].is_load) not_ready = 1'b1;
            else                      sel = FWD_MEMEX;
         end
         hit[ST_WB]: sel = FWD_WB;
         default: ;
      endcase
   end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller: writer scoreboard, stall/flush priority
// and a saturating stall-cycle counter.
module pipeline_hazard_controller
   import topaz_pkg::*;
#(
   parameter int NUM_REGS    = 16,
   parameter int STALL_CNT_W = 16
) (
   input logic clk,
   input logic rst,
   pipeline_hazard_controller_if.slave hz
);
   localparam int RW = $clog2(NUM_REGS);

   if (RW != REG_W) begin : g_bad_regs
      $error("NUM_REGS does not match REG_W");
   end

   sb_entry_t              sb [NUM_STAGES];
   sb_entry_t              id_entry;
   fwd_sel_t               sel1;
   fwd_sel_t               sel2;
   logic                   nr1;
   logic                   nr2;
   logic                   flush;
   logic                   stall;
   logic [STALL_CNT_W-1:0] cnt;

   hazard_src_resolver u_rs1 (
      .id_valid  (hz.id_valid),
      .rs        (hz.rs1_ID),
      .used      (hz.rs1_used_ID),
      .sb        (sb),
      .sel       (sel1),
      .not_ready (nr1)
   );

   hazard_src_resolver u_rs2 (
      .id_valid  (hz.id_valid),
      .rs        (hz.rs2_ID),
      .used      (hz.rs2_used_ID),
      .sb        (sb),
      .sel       (sel2),
      .not_ready (nr2)
   );

   // A taken branch discards the ID instruction, so it cannot stall.
   assign flush = hz.branch_taken_EX;
   assign stall = (nr1 | nr2) & ~flush;

   always_comb begin
      id_entry         = '0;
      id_entry.valid   = hz.id_valid;
      id_entry.rd      = hz.rd_ID;
      id_entry.we      = hz.regfile_we_ID;
      id_entry.is_load = hz.is_load_ID;
      if (stall | flush) id_entry = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            sb[k] <= '0;
         end
         cnt <= '0;
      end else begin
         sb[ST_WB]      <= sb[ST_MEMEX];
         sb[ST_MEMEX]   <= sb[ST_MEMPREP];
         sb[ST_MEMPREP] <= sb[ST_EX];
         sb[ST_EX]      <= id_entry;
         if (stall && !(&cnt)) cnt <= cnt + 1'b1;
      end
   end

   assign hz.stall        = stall;
   assign hz.invalid_IF   = flush;
   assign hz.invalid_ID   = flush;
   assign hz.fwd_sel_rs1  = sel1;
   assign hz.fwd_sel_rs2  = sel2;
   assign hz.stall_cycles = cnt;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: in-flight instruction list with ages
// predicts each cycle's controls; a monitor compares them.
module tb_pipeline_hazard_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;

   pipeline_hazard_controller_if #(.STALL_CNT_W(16)) bus ();

   pipeline_hazard_controller #(
      .NUM_REGS    (16),
      .STALL_CNT_W (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .hz  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] rd;
      logic       we;
      logic       ld;
      int         age;
   } inst_t;

   typedef struct {
      logic        stall;
      logic        iif;
      logic        iid;
      logic [2:0]  f1;
      logic [2:0]  f2;
      logic [15:0] cnt;
   } exp_t;

   inst_t infl [$];
   exp_t  exp_q [$];
   int    vectors = 0;
   int    miscompares = 0;
   int    cnt_m = 0;

   logic       last_v, last_u1, last_u2;
   logic       last_we, last_ld, last_br;
   logic       last_stall;
   logic [3:0] last_r1, last_r2, last_rd;

   task automatic chk(input string n, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  n, act, exp, $time);
      end
   endtask

   // Youngest in-flight writer of rs decides; loads ready at age 3.
   task automatic src_eval(input logic v, input logic [3:0] rs,
                           input logic used,
                           output logic [2:0] sel,
                           output logic unr);
      int best = -1;
      sel = 3'd0;
      unr = 1'b0;
      if (v && used && rs != 4'd0) begin
         foreach (infl[i]) begin
            if (infl[i].we && infl[i].rd == rs &&
                (best < 0 || infl[i].age < infl[best].age))
               best = i;
         end
      end
      if (best >= 0) begin
         if (infl[best].ld && infl[best].age != 3) unr = 1'b1;
         else sel = 3'(infl[best].age + 1);
      end
   endtask

   task automatic apply(input logic v,
                        input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2,
                        input logic [3:0] rd, input logic we,
                        input logic ld, input logic br);
      exp_t e;
      logic n1, n2;
      bus.id_valid        = v;
      bus.rs1_ID          = r1;
      bus.rs1_used_ID     = u1;
      bus.rs2_ID          = r2;
      bus.rs2_used_ID     = u2;
      bus.rd_ID           = rd;
      bus.regfile_we_ID   = we;
      bus.is_load_ID      = ld;
      bus.branch_taken_EX = br;
      src_eval(v, r1, u1, e.f1, n1);
      src_eval(v, r2, u2, e.f2, n2);
      e.stall = (n1 | n2) & ~br;
      e.iif   = br;
      e.iid   = br;
      e.cnt   = 16'(cnt_m);
      exp_q.push_back(e);
      last_v = v;  last_r1 = r1; last_u1 = u1;
      last_r2 = r2; last_u2 = u2; last_rd = rd;
      last_we = we; last_ld = ld; last_br = br;
      last_stall = e.stall;
   endtask

   task automatic advance();
      inst_t n;
      foreach (infl[i]) infl[i].age++;
      for (int i = infl.size() - 1; i >= 0; i--)
         if (infl[i].age > 3) infl.delete(i);
      if (last_stall && cnt_m != 16'hFFFF) cnt_m++;
      if (last_v && !last_stall && !last_br) begin
         n.rd = last_rd; n.we = last_we;
         n.ld = last_ld; n.age = 0;
         infl.push_back(n);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!rst) advance();
   endtask

   task automatic step(input logic v,
                       input logic [3:0] r1, input logic u1,
                       input logic [3:0] r2, input logic u2,
                       input logic [3:0] rd, input logic we,
                       input logic ld, input logic br);
      tick();
      apply(v, r1, u1, r2, u2, rd, we, ld, br);
   endtask

   // Reset keeps the ID inputs held so a pending stall must drop.
   task automatic do_reset();
      rst = 1'b1;
      infl.delete();
      cnt_m = 0;
      apply(last_v, last_r1, last_u1, last_r2, last_u2,
            last_rd, last_we, last_ld, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall",        int'(bus.stall),        int'(e.stall));
            chk("invalid_IF",   int'(bus.invalid_IF),   int'(e.iif));
            chk("invalid_ID",   int'(bus.invalid_ID),   int'(e.iid));
            chk("fwd_sel_rs1",  int'(bus.fwd_sel_rs1),  int'(e.f1));
            chk("fwd_sel_rs2",  int'(bus.fwd_sel_rs2),  int'(e.f2));
            chk("stall_cycles", int'(bus.stall_cycles), int'(e.cnt));
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic       v, u1, u2, we, ld, br;
      logic [3:0] r1, r2, rd;
      last_v = 0; last_u1 = 0; last_u2 = 0; last_we = 0;
      last_ld = 0; last_br = 0; last_stall = 0;
      last_r1 = 0; last_r2 = 0; last_rd = 0;
      apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
      void'(exp_q.pop_front());
      @(posedge clk);
      #1;
      do_reset();

      // ADD x1,x2,x0 with nothing in flight
      step(1, 4'd2, 1, 4'd0, 1, 4'd1, 1, 0, 0);
      // ADDI x3 then ADD x4,x3,x3, held for a second look
      step(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 0);
      step(1, 4'd3, 1, 4'd3, 1, 4'd4, 1, 0, 0);
      step(1, 4'd3, 1, 4'd0, 0, 4'd4, 1, 0, 0);
      // LW x5 then ADD x6,x5,x0: three stalls then WB bypass
      step(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1, 0);
      for (int i = 0; i < 4; i++)
         step(1, 4'd5, 1, 4'd0, 1, 4'd6, 1, 0, 0);
      step(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0);
      // ADDI x7, LW x7, use x7: younger load blocks bypass
      step(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 0, 0);
      step(1, 4'd0, 0, 4'd0, 0, 4'd7, 1, 1, 0);
      step(1, 4'd7, 1, 4'd0, 0, 4'd1, 1, 0, 0);
      step(1, 4'd7, 1, 4'd0, 0, 4'd1, 1, 0, 0);
      // Load-use dependency under a taken branch
      step(1, 4'd0, 0, 4'd0, 0, 4'd8, 1, 1, 0);
      step(1, 4'd8, 1, 4'd8, 1, 4'd9, 1, 0, 1);
      step(1, 4'd8, 1, 4'd0, 0, 4'd2, 1, 0, 0);
      // x0 writer and x0 consumer
      step(1, 4'd0, 0, 4'd0, 0, 4'd0, 1, 1, 0);
      step(1, 4'd0, 1, 4'd0, 1, 4'd3, 1, 0, 0);
      // Reset in the middle of a load-use stall
      step(1, 4'd0, 0, 4'd0, 0, 4'd10, 1, 1, 0);
      step(1, 4'd10, 1, 4'd0, 0, 4'd11, 1, 0, 0);
      tick();
      do_reset();
      step(1, 4'd10, 1, 4'd0, 0, 4'd11, 1, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         tick();
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
         end else begin
            if (last_stall && !last_br) begin
               v = last_v; r1 = last_r1; u1 = last_u1;
               r2 = last_r2; u2 = last_u2; rd = last_rd;
               we = last_we; ld = last_ld;
            end else begin
               v  = ($urandom_range(0, 9) != 0);
               r1 = 4'($urandom_range(0, 3));
               r2 = 4'($urandom_range(0, 3));
               u1 = 1'($urandom_range(0, 1));
               u2 = 1'($urandom_range(0, 1));
               rd = 4'($urandom_range(0, 3));
               we = ($urandom_range(0, 3) != 0);
               ld = ($urandom_range(0, 2) == 0);
            end
            br = ($urandom_range(0, 9) == 0);
            apply(v, r1, u1, r2, u2, rd, we, ld, br);
         end
      end

      tick();
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
